// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared run-state encoding and widths for cpu_run_ctrl
package cpu_run_ctrl_pkg;

  // Width of core program counters seen by the controller.
  localparam int PC_W = 32;

  // Width of the run-state register.
  localparam int ST_W = 3;

  // Run states; benches may decode these.
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RST_HOLD = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN      = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd3;
  localparam logic [ST_W-1:0] ST_TIMEOUT  = 3'd4;

  // A new run may only be launched from a resting state.
  function automatic logic st_accepts_start(input logic [ST_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// rtl/cpu_run_ctrl_sat_counter.sv - clearable up-counter that sticks at all-ones
module cpu_run_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  // Clear wins over enable; increments stop once every bit is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - core run controller: reset sequencing, counters, halt/timeout detection
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int               RESET_CYCLES = 4,
  parameter int               LOOP_HITS    = 3,
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] MAX_CYCLES   = CNT_W'(300000)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_retire,
  input  logic [PC_W-1:0]  i_retire_pc,
  output logic             o_cpu_reset,
  output logic             o_running,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retire_count,
  output logic [PC_W-1:0]  o_halt_pc
);

  // Hold counter only needs to reach RESET_CYCLES-1.
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  // Loop counter must be able to hold LOOP_HITS itself.
  localparam int LW = $clog2(LOOP_HITS + 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOP_HITS - 1);
  localparam logic [LW-1:0] LOOP_ONE  = LW'(1);

  // Timeout fires on the RUN cycle whose count is MAX_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST = MAX_CYCLES - CNT_W'(1);
  localparam logic             TO_EN   = (MAX_CYCLES != '0);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [LW-1:0]    r_loop_cnt;
  logic [PC_W-1:0]  r_halt_pc;
  logic [CNT_W-1:0] w_cycle_count;
  logic [CNT_W-1:0] w_retire_count;

  logic w_start_ok;
  logic w_in_hold;
  logic w_in_run;
  logic w_retire;
  logic w_pc_match;
  logic w_loop_hit;
  logic w_halt;
  logic w_timeout_hit;
  logic w_hold_done;

  assign w_start_ok    = i_start && st_accepts_start(r_state);
  assign w_in_hold     = (r_state == ST_RST_HOLD);
  assign w_in_run      = (r_state == ST_RUN);
  assign w_retire      = w_in_run && i_retire;
  assign w_pc_match    = (i_retire_pc == r_halt_pc);
  assign w_loop_hit    = w_retire && w_pc_match && (r_loop_cnt == LOOP_LAST);
  assign w_halt        = w_in_run && (i_halt_req || w_loop_hit);
  assign w_timeout_hit = TO_EN && w_in_run && (w_cycle_count == TO_LAST);
  assign w_hold_done   = w_in_hold && (r_hold_cnt == HOLD_LAST);

  // Next-state selection; a halt outranks a timeout in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (i_start) begin
          w_next_state = ST_RST_HOLD;
        end
      end
      ST_RST_HOLD: begin
        if (w_hold_done) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_halt) begin
          w_next_state = ST_DONE;
        end else if (w_timeout_hit) begin
          w_next_state = ST_TIMEOUT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Run-state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counts the cycles spent holding the core in reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hold_cnt <= '0;
    end else if (w_start_ok) begin
      r_hold_cnt <= '0;
    end else if (w_in_hold && !w_hold_done) begin
      r_hold_cnt <= r_hold_cnt + HOLD_ONE;
    end
  end

  // Last retired PC, also the reference for self-loop detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_halt_pc <= '0;
    end else if (w_start_ok) begin
      r_halt_pc <= '0;
    end else if (w_retire) begin
      r_halt_pc <= i_retire_pc;
    end
  end

  // Length of the current run of retires at one PC; idle cycles leave it alone.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_loop_cnt <= '0;
    end else if (w_start_ok) begin
      r_loop_cnt <= '0;
    end else if (w_retire) begin
      r_loop_cnt <= w_pc_match ? (r_loop_cnt + LOOP_ONE) : LOOP_ONE;
    end
  end

  cpu_run_ctrl_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clr   (w_start_ok),
    .i_en    (w_in_run),
    .o_count (w_cycle_count)
  );

  cpu_run_ctrl_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clr   (w_start_ok),
    .i_en    (w_retire),
    .o_count (w_retire_count)
  );

  // Status flags decode straight from the state register so reset acts immediately.
  assign o_cpu_reset    = !w_in_run;
  assign o_running      = w_in_run;
  assign o_done         = (r_state == ST_DONE);
  assign o_timeout      = (r_state == ST_TIMEOUT);
  assign o_cycle_count  = w_cycle_count;
  assign o_retire_count = w_retire_count;
  assign o_halt_pc      = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  localparam int RC = 4;
  localparam int LH = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        retire;
  logic [31:0] retire_pc;

  logic        a_cpu_reset, a_running, a_done, a_timeout;
  logic [31:0] a_cycle, a_retire, a_halt_pc;
  logic        b_cpu_reset, b_running, b_done, b_timeout;
  logic [7:0]  b_cycle, b_retire;
  logic [31:0] b_halt_pc;

  int n_cmp;
  int n_err;

  // Reference model: one slot per DUT instance.
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3, M_TO = 4;
  int          m_phase [2];
  int          m_hold  [2];
  longint      m_cyc   [2];
  longint      m_ret   [2];
  logic [31:0] m_last  [2];
  int          m_streak[2];
  longint      m_cap   [2];
  longint      m_max   [2];

  cpu_run_ctrl #(.RESET_CYCLES(RC), .LOOP_HITS(LH), .CNT_W(32), .MAX_CYCLES(32'd20)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_halt_req(halt_req),
    .i_retire(retire), .i_retire_pc(retire_pc),
    .o_cpu_reset(a_cpu_reset), .o_running(a_running), .o_done(a_done), .o_timeout(a_timeout),
    .o_cycle_count(a_cycle), .o_retire_count(a_retire), .o_halt_pc(a_halt_pc)
  );

  cpu_run_ctrl #(.RESET_CYCLES(RC), .LOOP_HITS(LH), .CNT_W(8), .MAX_CYCLES(8'd0)) dut_sat (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_halt_req(halt_req),
    .i_retire(retire), .i_retire_pc(retire_pc),
    .o_cpu_reset(b_cpu_reset), .o_running(b_running), .o_done(b_done), .o_timeout(b_timeout),
    .o_cycle_count(b_cycle), .o_retire_count(b_retire), .o_halt_pc(b_halt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_phase[k]  = M_IDLE;
    m_hold[k]   = 0;
    m_cyc[k]    = 0;
    m_ret[k]    = 0;
    m_last[k]   = '0;
    m_streak[k] = 0;
  endtask

  // One clock edge of the run controller, from the behavioural rules.
  task automatic model_step(input int k);
    bit halted;
    bit timed;
    if (!reset) begin
      model_reset(k);
    end else if (m_phase[k] == M_IDLE || m_phase[k] == M_DONE || m_phase[k] == M_TO) begin
      if (start) begin
        model_reset(k);
        m_phase[k] = M_HOLD;
        m_hold[k]  = RC;
      end
    end else if (m_phase[k] == M_HOLD) begin
      m_hold[k]--;
      if (m_hold[k] == 0) m_phase[k] = M_RUN;
    end else begin
      halted = halt_req;
      if (retire) begin
        if (m_ret[k] < m_cap[k]) m_ret[k]++;
        m_streak[k] = (retire_pc == m_last[k]) ? m_streak[k] + 1 : 1;
        m_last[k]   = retire_pc;
        if (m_streak[k] >= LH) halted = 1'b1;
      end
      timed = (m_max[k] != 0) && (m_cyc[k] + 1 == m_max[k]);
      if (m_cyc[k] < m_cap[k]) m_cyc[k]++;
      if (halted)      m_phase[k] = M_DONE;
      else if (timed)  m_phase[k] = M_TO;
    end
  endtask

  task automatic compare_all();
    chk("a_cpu_reset", 64'(a_cpu_reset), 64'(m_phase[0] != M_RUN));
    chk("a_running",   64'(a_running),   64'(m_phase[0] == M_RUN));
    chk("a_done",      64'(a_done),      64'(m_phase[0] == M_DONE));
    chk("a_timeout",   64'(a_timeout),   64'(m_phase[0] == M_TO));
    chk("a_cycle",     64'(a_cycle),     64'(m_cyc[0]));
    chk("a_retire",    64'(a_retire),    64'(m_ret[0]));
    chk("a_halt_pc",   64'(a_halt_pc),   64'(m_last[0]));
    chk("b_cpu_reset", 64'(b_cpu_reset), 64'(m_phase[1] != M_RUN));
    chk("b_running",   64'(b_running),   64'(m_phase[1] == M_RUN));
    chk("b_done",      64'(b_done),      64'(m_phase[1] == M_DONE));
    chk("b_timeout",   64'(b_timeout),   64'(m_phase[1] == M_TO));
    chk("b_cycle",     64'(b_cycle),     64'(m_cyc[1]));
    chk("b_retire",    64'(b_retire),    64'(m_ret[1]));
    chk("b_halt_pc",   64'(b_halt_pc),   64'(m_last[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt_req = 1'b0; retire = 1'b0; retire_pc = '0;
  endtask

  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (RC) cycle();
  endtask

  // Reset pulse landing between clock edges.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    chk("async_cpu_reset", 64'(a_cpu_reset), 64'd1);
    chk("async_cycle", 64'(a_cycle), 64'd0);
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_cap[0] = 64'hFFFF_FFFF; m_max[0] = 20;
    m_cap[1] = 64'hFF;        m_max[1] = 0;
    model_reset(0);
    model_reset(1);
    idle_inputs();
    reset = 1'b0;

    // T1: reset then idle.
    repeat (3) cycle();
    reset = 1'b1;
    repeat (3) cycle();
    chk("t1_cpu_reset", 64'(a_cpu_reset), 64'd1);
    chk("t1_running", 64'(a_running), 64'd0);

    // T2: reset hold length.
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < RC - 1; i++) begin
      cycle();
      chk("t2_hold", 64'(a_cpu_reset), 64'd1);
    end
    cycle();
    chk("t2_running", 64'(a_running), 64'd1);
    chk("t2_cpu_reset", 64'(a_cpu_reset), 64'd0);

    // T3: self-loop halt.
    begin
      logic [31:0] pcs [5];
      pcs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
      foreach (pcs[i]) begin
        retire = 1'b1; retire_pc = pcs[i];
        cycle();
      end
    end
    idle_inputs();
    chk("t3_done", 64'(a_done), 64'd1);
    chk("t3_retire", 64'(a_retire), 64'd5);
    chk("t3_halt_pc", 64'(a_halt_pc), 64'h8);

    // T4: explicit halt with same-cycle retire.
    do_start();
    repeat (10) cycle();
    halt_req = 1'b1; retire = 1'b1; retire_pc = 32'h100;
    cycle();
    idle_inputs();
    chk("t4_done", 64'(a_done), 64'd1);
    chk("t4_cycle", 64'(a_cycle), 64'd11);
    chk("t4_retire", 64'(a_retire), 64'd1);
    chk("t4_halt_pc", 64'(a_halt_pc), 64'h100);

    // T5: timeout with never-repeating PCs.
    do_start();
    for (int i = 0; i < 20; i++) begin
      retire = 1'b1; retire_pc = 32'h1000 + 32'(i) * 4;
      cycle();
    end
    idle_inputs();
    chk("t5_timeout", 64'(a_timeout), 64'd1);
    chk("t5_done", 64'(a_done), 64'd0);
    chk("t5_cycle", 64'(a_cycle), 64'd20);

    // Halt and timeout together: halt wins.
    do_start();
    repeat (19) cycle();
    halt_req = 1'b1;
    cycle();
    idle_inputs();
    chk("tie_done", 64'(a_done), 64'd1);
    chk("tie_timeout", 64'(a_timeout), 64'd0);
    chk("tie_cycle", 64'(a_cycle), 64'd20);

    // Counter saturation on the narrow instance.
    do_start();
    for (int i = 0; i < 300; i++) begin
      retire = 1'b1; retire_pc = 32'h2000 + 32'(i) * 4;
      cycle();
    end
    idle_inputs();
    chk("sat_cycle", 64'(b_cycle), 64'hFF);
    chk("sat_retire", 64'(b_retire), 64'hFF);
    chk("sat_running", 64'(b_running), 64'd1);

    // T6: async reset mid-run, then restart from DONE clears counts.
    do_start();
    repeat (3) cycle();
    async_reset();
    cycle();
    do_start();
    repeat (5) cycle();
    halt_req = 1'b1;
    cycle();
    idle_inputs();
    chk("t6_done", 64'(a_done), 64'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("t6_clr_cycle", 64'(a_cycle), 64'd0);
    chk("t6_clr_done", 64'(a_done), 64'd0);
    chk("t6_cpu_reset", 64'(a_cpu_reset), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      halt_req  = ($urandom_range(0, 39) == 0);
      retire    = ($urandom_range(0, 9) < 7);
      retire_pc = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
